// File: rtl/tri_raster_pkg.sv
// -----------------------------------------------------------------------------
// tri_raster_pkg
//    Shared types and default widths for the triangle scan controller.
//    COORD_W_DEF : unsigned coordinate width for vertices and pixels
//    CNT_W_DEF   : width of the saturating emitted-pixel counter
//    state_t     : controller FSM states
//    edge_idx_t  : index of the edge currently being evaluated (0..2)
// -----------------------------------------------------------------------------
package tri_raster_pkg;

   localparam int unsigned COORD_W_DEF = 12;
   localparam int unsigned CNT_W_DEF   = 24;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      EVAL,
      EMIT,
      DONE
   } state_t;

   typedef logic [1:0] edge_idx_t;

endpackage

// File: rtl/tri_raster_if.sv
// -----------------------------------------------------------------------------
// tri_raster_if
//    Triangle-in / pixel-out bundle of the scan controller.
//    tri_valid/tri_ready + x1..y3 : triangle handshake and vertex coordinates
//    pix_valid/pix_ready + pix_x/pix_y : inside-pixel stream
//    busy, done, pix_count        : status
//    master : geometry front end / pixel writer side
//    slave  : tri_raster_ctrl side
// -----------------------------------------------------------------------------
interface tri_raster_if
   import tri_raster_pkg::*;
#(
   parameter int unsigned COORD_W = COORD_W_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
);

   logic               tri_valid;
   logic               tri_ready;
   logic [COORD_W-1:0] x1, y1, x2, y2, x3, y3;
   logic               pix_valid;
   logic               pix_ready;
   logic [COORD_W-1:0] pix_x, pix_y;
   logic               busy;
   logic               done;
   logic [CNT_W-1:0]   pix_count;

   modport master (
      output tri_valid, x1, y1, x2, y2, x3, y3, pix_ready,
      input  tri_ready, pix_valid, pix_x, pix_y, busy, done, pix_count
   );

   modport slave (
      input  tri_valid, x1, y1, x2, y2, x3, y3, pix_ready,
      output tri_ready, pix_valid, pix_x, pix_y, busy, done, pix_count
   );

endinterface

// File: rtl/tri_edge_eval.sv
// -----------------------------------------------------------------------------
// tri_edge_eval
//    Combinational edge function E = (cx-Bx)*(Ay-By) - (Ax-Bx)*(cy-By),
//    computed at full precision (no truncation).
//    ax_i, ay_i, bx_i, by_i : edge vertices A and B
//    cx_i, cy_i             : pixel under test
//    e_o                    : signed edge value, 2*(COORD_W+1)+1 bits
//    ge0_o / le0_o          : E >= 0 / E <= 0
// -----------------------------------------------------------------------------
module tri_edge_eval #(
   parameter int unsigned COORD_W = 12
) (
   input  logic [COORD_W-1:0]              ax_i,
   input  logic [COORD_W-1:0]              ay_i,
   input  logic [COORD_W-1:0]              bx_i,
   input  logic [COORD_W-1:0]              by_i,
   input  logic [COORD_W-1:0]              cx_i,
   input  logic [COORD_W-1:0]              cy_i,
   output logic signed [2*(COORD_W+1):0]   e_o,
   output logic                            ge0_o,
   output logic                            le0_o
);

   localparam int unsigned PW = 2 * (COORD_W + 1);
   localparam int unsigned EW = PW + 1;

   logic signed [COORD_W:0] d_cx, d_ay, d_ax, d_cy;
   logic signed [PW-1:0]    p0, p1;

   // Zero-extended operands, so every difference fits COORD_W+1 signed bits.
   assign d_cx = $signed({1'b0, cx_i}) - $signed({1'b0, bx_i});
   assign d_ay = $signed({1'b0, ay_i}) - $signed({1'b0, by_i});
   assign d_ax = $signed({1'b0, ax_i}) - $signed({1'b0, bx_i});
   assign d_cy = $signed({1'b0, cy_i}) - $signed({1'b0, by_i});

   assign p0  = PW'(d_cx) * PW'(d_ay);
   assign p1  = PW'(d_ax) * PW'(d_cy);
   assign e_o = EW'(p0) - EW'(p1);

   assign ge0_o = ~e_o[EW-1];
   assign le0_o = e_o[EW-1] | (e_o == '0);

endmodule

// File: rtl/tri_raster_ctrl.sv
// -----------------------------------------------------------------------------
// tri_raster_ctrl
//    Accepts one triangle, walks its bounding box in raster order (x fastest),
//    evaluates the three edges one per cycle on a shared edge unit and emits
//    inside pixels (either winding, edges inclusive) on a valid/ready stream.
//    clk   : rising-edge clock
//    rst_n : asynchronous active-low reset
//    bus   : tri_raster_if slave (triangle in, pixels out, busy/done/pix_count)
// -----------------------------------------------------------------------------
module tri_raster_ctrl
   import tri_raster_pkg::*;
#(
   parameter int unsigned COORD_W = COORD_W_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   tri_raster_if.slave bus
);

   state_t             state_q;
   edge_idx_t          k_q;
   logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
   logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
   logic [COORD_W-1:0] cx_q, cy_q;
   logic [2:0]         pos_q, neg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               tri_ready_q, busy_q, done_q, pix_valid_q;

   logic [COORD_W-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
   logic [COORD_W-1:0] cx_d, cy_d;
   logic [COORD_W-1:0] ax, ay, bx, by;
   logic               at_end, inside_d;

   logic signed [2*(COORD_W+1):0] edge_e;
   logic                          edge_ge0, edge_le0;

   // Bounding box of the registered vertices, consumed in SETUP.
   always_comb begin
      xmin_d = x1_q;
      xmax_d = x1_q;
      ymin_d = y1_q;
      ymax_d = y1_q;
      if (x2_q < xmin_d) xmin_d = x2_q;
      if (x3_q < xmin_d) xmin_d = x3_q;
      if (x2_q > xmax_d) xmax_d = x2_q;
      if (x3_q > xmax_d) xmax_d = x3_q;
      if (y2_q < ymin_d) ymin_d = y2_q;
      if (y3_q < ymin_d) ymin_d = y3_q;
      if (y2_q > ymax_d) ymax_d = y2_q;
      if (y3_q > ymax_d) ymax_d = y3_q;
   end

   // Raster step; never used at the last pixel, so it cannot wrap.
   assign at_end = (cx_q == xmax_q) && (cy_q == ymax_q);

   always_comb begin
      cx_d = cx_q + COORD_W'(1);
      cy_d = cy_q;
      if (cx_q == xmax_q) begin
         cx_d = xmin_q;
         cy_d = cy_q + COORD_W'(1);
      end
   end

   // Edge k: 0=(V1,V2), 1=(V2,V3), 2=(V3,V1).
   always_comb begin
      ax = x1_q; ay = y1_q; bx = x2_q; by = y2_q;
      case (k_q)
         2'd1:    begin ax = x2_q; ay = y2_q; bx = x3_q; by = y3_q; end
         2'd2:    begin ax = x3_q; ay = y3_q; bx = x1_q; by = y1_q; end
         default: begin ax = x1_q; ay = y1_q; bx = x2_q; by = y2_q; end
      endcase
   end

   tri_edge_eval #(.COORD_W(COORD_W)) u_edge (
      .ax_i  (ax),
      .ay_i  (ay),
      .bx_i  (bx),
      .by_i  (by),
      .cx_i  (cx_q),
      .cy_i  (cy_q),
      .e_o   (edge_e),
      .ge0_o (edge_ge0),
      .le0_o (edge_le0)
   );

   // Edge 2 is decided from the live edge unit so the verdict costs no extra cycle.
   assign inside_d = (edge_ge0 & pos_q[0] & pos_q[1]) | (edge_le0 & neg_q[0] & neg_q[1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         x1_q        <= '0; y1_q <= '0;
         x2_q        <= '0; y2_q <= '0;
         x3_q        <= '0; y3_q <= '0;
         xmin_q      <= '0; xmax_q <= '0;
         ymin_q      <= '0; ymax_q <= '0;
         cx_q        <= '0; cy_q <= '0;
         pos_q       <= '0; neg_q <= '0;
         cnt_q       <= '0;
         tri_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pix_valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.tri_valid) begin
                  x1_q <= bus.x1; y1_q <= bus.y1;
                  x2_q <= bus.x2; y2_q <= bus.y2;
                  x3_q <= bus.x3; y3_q <= bus.y3;
                  cnt_q       <= '0;
                  tri_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= SETUP;
               end
            end
            SETUP: begin
               xmin_q  <= xmin_d; xmax_q <= xmax_d;
               ymin_q  <= ymin_d; ymax_q <= ymax_d;
               cx_q    <= xmin_d;
               cy_q    <= ymin_d;
               k_q     <= '0;
               state_q <= EVAL;
            end
            EVAL: begin
               pos_q[k_q] <= edge_ge0;
               neg_q[k_q] <= edge_le0;
               if (k_q == 2'd2) begin
                  k_q <= '0;
                  if (inside_d) begin
                     pix_valid_q <= 1'b1;
                     state_q     <= EMIT;
                  end else if (at_end) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     cx_q <= cx_d;
                     cy_q <= cy_d;
                  end
               end else begin
                  k_q <= k_q + 2'd1;
               end
            end
            EMIT: begin
               if (bus.pix_ready) begin
                  pix_valid_q <= 1'b0;
                  if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                  if (at_end) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     cx_q    <= cx_d;
                     cy_q    <= cy_d;
                     state_q <= EVAL;
                  end
               end
            end
            DONE: begin
               busy_q      <= 1'b0;
               tri_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               tri_ready_q <= 1'b1;
               pix_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tri_ready = tri_ready_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_x     = cx_q;
   assign bus.pix_y     = cy_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pix_count = cnt_q;

   // Full edge value is only consumed through its sign flags here.
   logic unused_edge;
   assign unused_edge = ^edge_e;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
`timescale 1ns/1ps
module tb_tri_raster_ctrl;
   import tri_raster_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tri_raster_if #(.COORD_W(COORD_W_DEF), .CNT_W(CNT_W_DEF)) bus ();

   tri_raster_ctrl #(.COORD_W(COORD_W_DEF), .CNT_W(CNT_W_DEF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned done_pulses = 0;
   logic [23:0] cap_q[$];
   logic [23:0] exp_q[$];

   // Handshake observed at the negedge completes at the following posedge.
   always @(negedge clk) begin
      if (rst_n && bus.pix_valid && bus.pix_ready) cap_q.push_back({bus.pix_x, bus.pix_y});
      if (rst_n && bus.done) done_pulses++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] pk(input int x, input int y);
      logic [31:0] xv, yv;
      xv = x;
      yv = y;
      return {xv[11:0], yv[11:0]};
   endfunction

   function automatic longint edge_fn(input longint ax, ay, bx, by, cx, cy);
      return (cx - bx) * (ay - by) - (ax - bx) * (cy - by);
   endfunction

   function automatic int min3(input int a, b, c);
      int m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      return m;
   endfunction

   function automatic int max3(input int a, b, c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   task automatic build_model(input int x1, y1, x2, y2, x3, y3, output int nbox);
      int xmn, xmx, ymn, ymx;
      longint e0, e1, e2;
      xmn = min3(x1, x2, x3); xmx = max3(x1, x2, x3);
      ymn = min3(y1, y2, y3); ymx = max3(y1, y2, y3);
      exp_q.delete();
      for (int y = ymn; y <= ymx; y++) begin
         for (int x = xmn; x <= xmx; x++) begin
            e0 = edge_fn(x1, y1, x2, y2, x, y);
            e1 = edge_fn(x2, y2, x3, y3, x, y);
            e2 = edge_fn(x3, y3, x1, y1, x, y);
            if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
               exp_q.push_back(pk(x, y));
         end
      end
      nbox = (xmx - xmn + 1) * (ymx - ymn + 1);
   endtask

   task automatic offer(input int x1, y1, x2, y2, x3, y3);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.tri_ready) begin
            seen = 1'b1;
            break;
         end
      end
      check("tri_ready_wait", seen, 1);
      bus.x1 = 12'(x1); bus.y1 = 12'(y1);
      bus.x2 = 12'(x2); bus.y2 = 12'(y2);
      bus.x3 = 12'(x3); bus.y3 = 12'(y3);
      bus.tri_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.tri_valid = 1'b0;
   endtask

   // Returns the cycle (1 = cycle starting at the accept edge) in which done is seen.
   task automatic scan(input bit bp, input int unsigned budget, output int unsigned lat);
      int unsigned stalls;
      bit got;
      stalls = 0;
      got = 1'b0;
      lat = 0;
      for (int unsigned i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (bp && stalls > 0 && !bus.pix_ready) begin
            check("bp_valid_held", bus.pix_valid, 1);
            check("bp_pix_stable", {bus.pix_x, bus.pix_y}, {12'd1, 12'd0});
         end
         if (bus.done) begin
            lat = i;
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (bp) begin
            if (bus.pix_valid && bus.pix_x == 12'd1 && bus.pix_y == 12'd0 && stalls < 5) begin
               bus.pix_ready = 1'b0;
               stalls++;
            end else begin
               bus.pix_ready = 1'b1;
            end
         end
      end
      check("done_seen", got, 1);
   endtask

   task automatic compare_list(input string tag, input int base);
      int n;
      n = cap_q.size() - base;
      check({tag, "_count"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         check({tag, "_pix"}, cap_q[base + i], exp_q[i]);
   endtask

   function automatic bit has_pix(input int base, input logic [23:0] p);
      for (int i = base; i < cap_q.size(); i++)
         if (cap_q[i] == p) return 1'b1;
      return 1'b0;
   endfunction

   task automatic load_t2_list();
      exp_q.delete();
      exp_q.push_back(pk(0, 0)); exp_q.push_back(pk(1, 0)); exp_q.push_back(pk(2, 0));
      exp_q.push_back(pk(0, 1)); exp_q.push_back(pk(1, 1)); exp_q.push_back(pk(0, 2));
   endtask

   initial begin
      int base, base2, nbox, dp;
      int unsigned lat;
      int bx0, by0, v[6];
      bit seen;

      bus.tri_valid = 1'b0;
      bus.pix_ready = 1'b1;
      bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0; bus.x3 = '0; bus.y3 = '0;

      // 1: reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tri_ready", bus.tri_ready, 1);
      check("rst_pix_valid", bus.pix_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_pix_count", bus.pix_count, 0);
      check("rst_pix_xy", {bus.pix_x, bus.pix_y}, 0);
      rst_n = 1'b1;

      // 2: small right triangle, full order and latency
      base = cap_q.size();
      load_t2_list();
      offer(0, 0, 2, 0, 0, 2);
      scan(1'b0, 200, lat);
      compare_list("t2", base);
      check("t2_latency", lat, 35);
      check("t2_pix_count", bus.pix_count, 6);
      check("t2_busy_in_done", bus.busy, 1);
      @(negedge clk);
      check("t2_done_pulse", bus.done, 0);
      check("t2_idle_busy", bus.busy, 0);

      // 3: larger triangle, both windings
      build_model(10, 10, 30, 10, 20, 30, nbox);
      base = cap_q.size();
      offer(10, 10, 30, 10, 20, 30);
      scan(1'b0, 3000, lat);
      compare_list("t3", base);
      check("t3_has_15_15", has_pix(base, pk(15, 15)), 1);
      check("t3_has_vertex", has_pix(base, pk(10, 10)), 1);
      check("t3_no_9_15", has_pix(base, pk(9, 15)), 0);
      check("t3_latency", lat, 1 + 3 * nbox + exp_q.size() + 1);
      base2 = cap_q.size();
      offer(20, 30, 30, 10, 10, 10);
      scan(1'b0, 3000, lat);
      compare_list("t3_rev", base2);

      // 4: backpressure on (1,0)
      base = cap_q.size();
      load_t2_list();
      offer(0, 0, 2, 0, 0, 2);
      scan(1'b1, 200, lat);
      bus.pix_ready = 1'b1;
      compare_list("t4", base);
      check("t4_latency", lat, 40);
      check("t4_pix_count", bus.pix_count, 6);

      // 5: single-point triangle; tri_valid held while busy
      base = cap_q.size();
      exp_q.delete();
      exp_q.push_back(pk(5, 5));
      offer(5, 5, 5, 5, 5, 5);
      bus.x1 = 12'd7; bus.y1 = 12'd7; bus.x2 = 12'd7; bus.y2 = 12'd7; bus.x3 = 12'd7; bus.y3 = 12'd7;
      bus.tri_valid = 1'b1;
      scan(1'b0, 100, lat);
      check("t5_latency", lat, 6);
      check("t5_ready_in_done", bus.tri_ready, 0);
      @(posedge clk);
      #1;
      bus.tri_valid = 1'b0;
      @(negedge clk);
      check("t5_idle_ready", bus.tri_ready, 1);
      @(negedge clk);
      check("t5_not_reaccepted", bus.busy, 0);
      compare_list("t5", base);
      check("t5_pix_count", bus.pix_count, 1);

      // 6: reset while a pixel is pending
      base = cap_q.size();
      bus.pix_ready = 1'b0;
      offer(0, 0, 2, 0, 0, 2);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.pix_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("t6_reached_emit", seen, 1);
      dp = done_pulses;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_pix_valid", bus.pix_valid, 0);
      check("t6_async_busy", bus.busy, 0);
      check("t6_async_tri_ready", bus.tri_ready, 1);
      check("t6_async_count", bus.pix_count, 0);
      repeat (2) @(negedge clk);
      check("t6_async_done", bus.done, 0);
      rst_n = 1'b1;
      bus.pix_ready = 1'b1;
      check("t6_no_done_pulse", done_pulses, dp);
      check("t6_no_partial_pix", cap_q.size(), base);
      load_t2_list();
      offer(0, 0, 2, 0, 0, 2);
      scan(1'b0, 200, lat);
      compare_list("t6_rescan", base);
      check("t6_latency", lat, 35);

      // Scoreboard: random small triangles anywhere in 0..4095
      for (int r = 0; r < 8; r++) begin
         bx0 = (r == 0) ? 4091 : (r == 1) ? 0 : $urandom_range(0, 4091);
         by0 = (r == 0) ? 4091 : (r == 1) ? 0 : $urandom_range(0, 4091);
         for (int j = 0; j < 3; j++) begin
            v[2*j]   = bx0 + $urandom_range(0, 4);
            v[2*j+1] = by0 + $urandom_range(0, 4);
         end
         build_model(v[0], v[1], v[2], v[3], v[4], v[5], nbox);
         base = cap_q.size();
         offer(v[0], v[1], v[2], v[3], v[4], v[5]);
         scan(1'b0, 300, lat);
         compare_list("rnd", base);
         check("rnd_latency", lat, 1 + 3 * nbox + exp_q.size() + 1);
         check("rnd_pix_count", bus.pix_count, exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
